// File: rtl/mips_cpu_bus_arbiter.sv
// Shares the CPU's single Avalon master port between instruction fetch and load/store.
// One transaction at a time; simultaneous requests alternate round-robin.
module mips_cpu_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_read,
  input  logic [31:0] if_address,
  output logic [31:0] if_readdata,
  output logic        if_done,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_readdata,
  output logic        d_done,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic        r_last;
  logic        r_gnt_d;
  logic [31:0] r_address;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_writedata;
  logic [3:0]  r_byteenable;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic w_d_req;
  logic w_grant_d;

  assign w_d_req = d_read | d_write;
  // Data wins when it is the only requester, or on a tie when fetch had the last grant.
  assign w_grant_d = w_d_req & (~if_read | ~r_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_gnt_d      <= 1'b0;
      r_address    <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= '0;
      r_byteenable <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (if_read | w_d_req) begin
            r_state <= S_BUS;
            r_last  <= w_grant_d;
            r_gnt_d <= w_grant_d;
            if (w_grant_d) begin
              // A simultaneous read+write request is issued as a write.
              r_address    <= d_address;
              r_byteenable <= d_byteenable;
              r_write      <= d_write;
              r_read       <= ~d_write;
              r_writedata  <= d_write ? d_writedata : 32'd0;
            end else begin
              r_address    <= if_address;
              r_byteenable <= 4'b1111;
              r_write      <= 1'b0;
              r_read       <= 1'b1;
              r_writedata  <= 32'd0;
            end
          end
        end
        S_BUS: begin
          if (!waitrequest) begin
            if (r_read) begin
              if (r_gnt_d) r_d_rdata <= readdata;
              else         r_if_rdata <= readdata;
            end
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_state      <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign address     = r_address;
  assign read        = r_read;
  assign write       = r_write;
  assign writedata   = r_writedata;
  assign byteenable  = r_byteenable;
  assign if_readdata = r_if_rdata;
  assign d_readdata  = r_d_rdata;
  assign if_done     = (r_state == S_DONE) & ~r_gnt_d;
  assign d_done      = (r_state == S_DONE) &  r_gnt_d;
  assign busy        = (r_state == S_BUS) | (r_state == S_DONE);

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Randomized bench: the bench plays both requesters and the Avalon slave, and a
// transaction-level model predicts grants, bus values, done pulses and read data.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_read;
  logic [31:0] if_address;
  logic [31:0] if_readdata;
  logic        if_done;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_done;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        busy;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .if_read(if_read), .if_address(if_address), .if_readdata(if_readdata), .if_done(if_done),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_readdata(d_readdata), .d_done(d_done),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit          pend_f, pend_d;
  bit          m_last;
  logic [31:0] m_if_rd, m_d_rd;
  bit          g_data;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_be;
  bit          e_rd, e_wr;

  task automatic check_bus(input string tag, input bit active);
    if (active) begin
      check({tag, ".address"}, address, e_addr);
      check({tag, ".read"}, 32'(read), 32'(e_rd));
      check({tag, ".write"}, 32'(write), 32'(e_wr));
      check({tag, ".writedata"}, writedata, e_wd);
      check({tag, ".byteenable"}, 32'(byteenable), 32'(e_be));
    end else begin
      check({tag, ".bus_idle"}, {address ^ writedata, 4'b0, byteenable},
            32'd0);
      check({tag, ".rw_idle"}, 32'({read, write, address == 32'd0, writedata == 32'd0}), 32'b0011);
    end
  endtask

  task automatic check_status(input string tag, input bit exp_busy, input logic [1:0] exp_done);
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".done"}, 32'({if_done, d_done}), 32'(exp_done));
  endtask

  task automatic check_rdata(input string tag);
    check({tag, ".if_readdata"}, if_readdata, m_if_rd);
    check({tag, ".d_readdata"}, d_readdata, m_d_rd);
  endtask

  task automatic drive_data_req();
    int kind;
    kind = $urandom_range(0, 2);
    d_read       = (kind != 1);
    d_write      = (kind != 0);
    d_address    = $urandom & 32'hffff_fffc;
    d_writedata  = $urandom;
    d_byteenable = 4'($urandom_range(1, 15));
  endtask

  initial begin
    int  waits;
    bit  do_reset;
    reset = 1'b1;
    if_read = 0; if_address = 0;
    d_read = 0; d_write = 0; d_address = 0; d_writedata = 0; d_byteenable = 0;
    waitrequest = 0; readdata = 0;
    pend_f = 0; pend_d = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_last = 1'b1; m_if_rd = 0; m_d_rd = 0;
    check_bus("reset", 1'b0);
    check_status("reset", 1'b0, 2'b00);
    check_rdata("reset");

    for (int it = 0; it < 80; it++) begin
      // IDLE cycle: present requests
      if (it == 0) begin
        pend_f = 1; if_read = 1; if_address = 32'h0000_0100;
      end else if (it == 1) begin
        pend_d = 1; d_read = 1; d_write = 1; d_address = 32'h0000_0200;
        d_writedata = 32'hdeadbeef; d_byteenable = 4'b0011;
      end else begin
        if (!pend_f && $urandom_range(0, 2) != 0) begin
          pend_f = 1; if_read = 1; if_address = $urandom & 32'hffff_fffc;
        end
        if (!pend_d && $urandom_range(0, 2) != 0) begin
          pend_d = 1; drive_data_req();
        end
        if (!pend_f && !pend_d) begin
          pend_f = 1; if_read = 1; if_address = $urandom & 32'hffff_fffc;
        end
      end
      waitrequest = 1'($urandom);

      g_data = (pend_f && pend_d) ? !m_last : pend_d;
      m_last = g_data;
      if (g_data) begin
        e_addr = d_address; e_be = d_byteenable;
        e_wr = d_write; e_rd = !d_write;
        e_wd = d_write ? d_writedata : 32'd0;
      end else begin
        e_addr = if_address; e_be = 4'hf; e_wr = 0; e_rd = 1; e_wd = 0;
      end
      waits    = (it == 0) ? 0 : (it == 2) ? 3 : $urandom_range(0, 3);
      do_reset = (it > 4) && ($urandom_range(0, 9) == 0);

      @(posedge clk); @(negedge clk);
      check_bus("grant", 1'b1);
      check_status("grant", 1'b1, 2'b00);

      if (do_reset) begin
        waitrequest = 1'b1;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        m_last = 1'b1; m_if_rd = 0; m_d_rd = 0;
        check_bus("abort", 1'b0);
        check_status("abort", 1'b0, 2'b00);
        check_rdata("abort");
        $display("txn %0d: %s abandoned by reset", it, g_data ? "data" : "fetch");
        continue;
      end

      for (int w = 0; w < waits; w++) begin
        waitrequest = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          // requester drops mid-transaction; bus must not notice
          if (g_data) begin d_read = 0; d_write = 0; d_address = $urandom; end
          else begin if_read = 0; if_address = $urandom; end
        end
        @(posedge clk); @(negedge clk);
        check_bus("hold", 1'b1);
        check_status("hold", 1'b1, 2'b00);
      end

      waitrequest = 1'b0;
      readdata = (it == 0) ? 32'h2442000f : $urandom;
      @(posedge clk); @(negedge clk);
      if (e_rd) begin
        if (g_data) m_d_rd = readdata;
        else        m_if_rd = readdata;
      end
      check_bus("done", 1'b0);
      check_status("done", 1'b1, g_data ? 2'b01 : 2'b10);
      check_rdata("done");
      $display("txn %0d: %s %s addr=%h waits=%0d rdata=%h", it, g_data ? "data" : "fetch",
               e_wr ? "write" : "read", e_addr, waits, e_rd ? readdata : 32'd0);

      if (g_data) begin pend_d = 0; d_read = 0; d_write = 0; end
      else        begin pend_f = 0; if_read = 0; end
      waitrequest = 1'($urandom);
      readdata = $urandom;
      @(posedge clk); @(negedge clk);
      check_bus("idle", 1'b0);
      check_status("idle", 1'b0, 2'b00);
      check_rdata("idle");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
